// File: rtl/gbdt_pkg.sv
`default_nettype none
// ============================================================================
// gbdt_pkg : shared types, constants and saturating arithmetic for the GBDT core
// Revision : 1.0
// ============================================================================
`ifndef RAM_ADDR_WIDTH
`define RAM_ADDR_WIDTH 8
`endif

package gbdt_pkg;

    localparam int NUM_GROUPS     = 8;
    localparam int RAMS_PER_GROUP = 4;

    localparam logic [31:0] SCORE_MIN = 32'h8000_0000;
    localparam logic [31:0] SCORE_MAX = 32'h7FFF_FFFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DRAIN = 3'd2,
        CMP   = 3'd3,
        DONE  = 3'd4
    } gbdt_core_state_t;

    // Overflow only when both operands share a sign and the sum's sign differs.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        s = a + b;
        if ((a[31] == b[31]) && (s[31] != a[31]))
            return a[31] ? SCORE_MIN : SCORE_MAX;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gbdt_sat_acc.sv
`default_nettype none
// ============================================================================
// gbdt_sat_acc : per-group signed saturating accumulator with clear and enable
// Revision     : 1.0
// ============================================================================
module gbdt_sat_acc
    import gbdt_pkg::*;
(
    input  logic        gbdt_clk,
    input  logic        gbdt_rst_n,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [31:0] i_din,
    output logic [31:0] o_acc
);

    logic [31:0] r_acc;

    always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
        if (!gbdt_rst_n)
            r_acc <= '0;
        else if (i_clr)
            r_acc <= '0;
        else if (i_en)
            r_acc <= sat_add(r_acc, i_din);
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/gbdt_score_engine.sv
`default_nettype none
// ============================================================================
// gbdt_score_engine : sweeps the four RAM rounds, sums leaf scores per class
//                     and tracks the signed arg-max over enabled classes
// Revision          : 1.0
// ============================================================================
module gbdt_score_engine
    import gbdt_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH  = `RAM_ADDR_WIDTH,
    parameter int RAM_DATA_WIDTH  = 32,
    parameter int WORDS_PER_CLASS = 4
)
(
    input  logic                                  gbdt_clk,
    input  logic                                  gbdt_rst_n,
    input  logic                                  gbdt_start,
    input  logic [31:0]                           used_classes,
    input  logic                                  load_mode,
    input  logic [7:0][RAM_DATA_WIDTH-1:0]        data_from_rams,
    output logic                                  we,
    output logic                                  cs,
    output logic                                  oe,
    output logic [1:0]                            round,
    output logic [7:0][RAM_ADDR_WIDTH-1:0]        ram_address,
    output logic [31:0]                           new_max_result,
    output logic [4:0]                            new_max_class,
    output logic                                  busy,
    output logic                                  done
);

    // One spare bit so the counter can reach 2^RAM_ADDR_WIDTH words.
    localparam int               CNT_W       = RAM_ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] c_last_word = CNT_W'(WORDS_PER_CLASS - 1);

    gbdt_core_state_t r_state, w_next_state;

    logic [CNT_W-1:0]             r_word_cnt;
    logic [2:0]                   r_grp_cnt;
    logic [1:0]                   r_round;
    logic [31:0]                  r_max_result;
    logic [4:0]                   r_max_class;
    logic [NUM_GROUPS-1:0][31:0]  w_acc;
    logic                         w_start_ok, w_read_last, w_cmp_last, w_last_round;
    logic                         w_acc_clr, w_acc_en, w_cmp_hit;
    logic                         w_cs, w_busy, w_done;
    logic [31:0]                  w_cmp_acc;
    logic [4:0]                   w_cmp_class;

    assign w_start_ok   = (r_state == IDLE) && gbdt_start;
    assign w_read_last  = (r_word_cnt == c_last_word);
    assign w_cmp_last   = (r_grp_cnt == 3'd7);
    assign w_last_round = (r_round == 2'(RAMS_PER_GROUP - 1));
    assign w_acc_clr    = w_start_ok || ((r_state == CMP) && w_cmp_last && !w_last_round);
    // RAM data lags the address by one cycle, so the first READ cycle has nothing to add.
    assign w_acc_en     = ((r_state == READ) && (r_word_cnt != '0)) || (r_state == DRAIN);

    assign w_cmp_acc    = w_acc[r_grp_cnt];
    assign w_cmp_class  = {r_round, r_grp_cnt};
    assign w_cmp_hit    = used_classes[w_cmp_class] &&
                          ($signed(w_cmp_acc) > $signed(r_max_result));

    always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
        if (!gbdt_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (gbdt_start)  w_next_state = READ;
            READ:    if (w_read_last) w_next_state = DRAIN;
            DRAIN:                    w_next_state = CMP;
            CMP:     if (w_cmp_last)  w_next_state = w_last_round ? DONE : READ;
            DONE:                     w_next_state = IDLE;
            default:                  w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_cs   = (r_state == READ);
        w_busy = (r_state != IDLE) && (r_state != DONE);
        w_done = (r_state == DONE);
    end

    always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
        if (!gbdt_rst_n) begin
            r_word_cnt   <= '0;
            r_grp_cnt    <= '0;
            r_round      <= '0;
            r_max_result <= '0;
            r_max_class  <= '0;
        end else begin
            if (w_acc_clr)
                r_word_cnt <= '0;
            else if (r_state == READ)
                r_word_cnt <= r_word_cnt + CNT_W'(1);

            if (r_state == CMP)
                r_grp_cnt <= r_grp_cnt + 3'd1;

            if (w_start_ok)
                r_round <= '0;
            else if ((r_state == CMP) && w_cmp_last)
                r_round <= w_last_round ? 2'd0 : r_round + 2'd1;

            // Strict greater-than keeps the lower class index on ties.
            if (w_start_ok) begin
                r_max_result <= SCORE_MIN;
                r_max_class  <= '0;
            end else if ((r_state == CMP) && w_cmp_hit) begin
                r_max_result <= w_cmp_acc;
                r_max_class  <= w_cmp_class;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
            gbdt_sat_acc u_acc (
                .gbdt_clk   (gbdt_clk),
                .gbdt_rst_n (gbdt_rst_n),
                .i_clr      (w_acc_clr),
                .i_en       (w_acc_en),
                .i_din      (32'($signed(data_from_rams[g]))),
                .o_acc      (w_acc[g])
            );
            assign ram_address[g] = w_cs ? r_word_cnt[RAM_ADDR_WIDTH-1:0] : '0;
        end
    endgenerate

    assign we             = load_mode & ~w_busy;
    assign cs             = w_cs;
    assign oe             = w_cs;
    assign round          = r_round;
    assign busy           = w_busy;
    assign done           = w_done;
    assign new_max_result = r_max_result;
    assign new_max_class  = r_max_class;

endmodule
`default_nettype wire

// File: tb/tb_gbdt_score_engine.sv
`default_nettype none
// ============================================================================
// tb_gbdt_score_engine : directed self-checking bench with a synchronous RAM model
// Revision             : 1.0
// ============================================================================
module tb_gbdt_score_engine;

    logic             gbdt_clk;
    logic             gbdt_rst_n;
    logic             gbdt_start;
    logic [31:0]      used_classes;
    logic             load_mode;
    logic [7:0][31:0] data_from_rams;
    logic             we, cs, oe, busy, done;
    logic [1:0]       round;
    logic [7:0][7:0]  ram_address;
    logic [31:0]      new_max_result;
    logic [4:0]       new_max_class;

    logic [31:0] mem [0:31][0:3];
    int checks   = 0;
    int failures = 0;
    int done_cyc;

    gbdt_score_engine #(
        .RAM_ADDR_WIDTH  (8),
        .RAM_DATA_WIDTH  (32),
        .WORDS_PER_CLASS (4)
    ) dut (
        .gbdt_clk       (gbdt_clk),
        .gbdt_rst_n     (gbdt_rst_n),
        .gbdt_start     (gbdt_start),
        .used_classes   (used_classes),
        .load_mode      (load_mode),
        .data_from_rams (data_from_rams),
        .we             (we),
        .cs             (cs),
        .oe             (oe),
        .round          (round),
        .ram_address    (ram_address),
        .new_max_result (new_max_result),
        .new_max_class  (new_max_class),
        .busy           (busy),
        .done           (done)
    );

    initial gbdt_clk = 1'b0;
    always #5 gbdt_clk = ~gbdt_clk;

    // Registered-read RAM: class = group + 8*round.
    always @(posedge gbdt_clk) begin
        for (int g = 0; g < 8; g++)
            if (cs && oe)
                data_from_rams[g] <= mem[int'(round) * 8 + g][ram_address[g][1:0]];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge gbdt_clk);
        #1;
    endtask

    task automatic fill_basic();
        for (int c = 0; c < 32; c++)
            for (int k = 0; k < 4; k++)
                mem[c][k] = 32'(c);
    endtask

    task automatic fill_const(input logic [31:0] v);
        for (int c = 0; c < 32; c++)
            for (int k = 0; k < 4; k++)
                mem[c][k] = v;
    endtask

    // Cycle 1 is the first busy/READ cycle; returns the cycle on which done is seen (0 = timeout).
    task automatic run_sweep(input logic [31:0] mask, input bit chk_seq, input bit chk_ctl,
                             output int dcyc);
        int cyc;
        int r;
        int pos;
        used_classes = mask;
        gbdt_start   = 1'b1;
        tick();
        gbdt_start   = 1'b0;
        cyc  = 1;
        dcyc = 0;
        check("busy_rise", 64'(busy), 64'd1);
        while (dcyc == 0 && cyc < 200) begin
            r   = (cyc - 1) / 13;
            pos = (cyc - 1) % 13;
            if (chk_seq && cyc <= 52) begin
                check("cs_seq", 64'({cs, oe}), (pos < 4) ? 64'd3 : 64'd0);
                if (pos < 4) begin
                    check("round_seq", 64'(round), 64'(r));
                    check("addr_seq", 64'(ram_address), {8{8'(pos)}});
                end
            end
            if (chk_ctl && cyc <= 52)
                check("we_busy", 64'(we), 64'd0);
            if (done) begin
                dcyc = cyc;
            end else begin
                gbdt_start = chk_ctl && (cyc == 10);
                tick();
                cyc++;
            end
        end
        gbdt_start = 1'b0;
        check("done_cycle", 64'(dcyc), 64'd53);
        check("busy_at_done", 64'(busy), 64'd0);
    endtask

    initial begin
        gbdt_rst_n   = 1'b0;
        gbdt_start   = 1'b0;
        used_classes = '0;
        load_mode    = 1'b0;
        fill_basic();
        tick();
        tick();
        check("rst_we",    64'(we), 64'd0);
        check("rst_cs_oe", 64'({cs, oe}), 64'd0);
        check("rst_round", 64'(round), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_done",  64'(done), 64'd0);
        check("rst_addr",  64'(ram_address), 64'd0);
        check("rst_max",   64'(new_max_result), 64'd0);
        check("rst_class", 64'(new_max_class), 64'd0);
        gbdt_rst_n = 1'b1;
        tick();
        tick();

        // Basic arg-max: class c sums to 4c.
        run_sweep(32'hFFFF_FFFF, 1'b1, 1'b0, done_cyc);
        check("basic_max",   64'(new_max_result), 64'd124);
        check("basic_class", 64'(new_max_class), 64'd31);
        tick();
        check("basic_done_pulse", 64'(done), 64'd0);

        // Mask to round 0 only.
        run_sweep(32'h0000_00FF, 1'b1, 1'b0, done_cyc);
        check("mask_max",   64'(new_max_result), 64'd28);
        check("mask_class", 64'(new_max_class), 64'd7);
        tick();

        // Tie on -3 between classes 5 and 20.
        fill_const(32'd0);
        for (int c = 0; c < 32; c++) mem[c][0] = -32'sd10;
        mem[5]  = '{-32'sd3, 32'd0, 32'd0, 32'd0};
        mem[20] = '{-32'sd1, -32'sd1, -32'sd1, 32'd0};
        run_sweep(32'hFFFF_FFFF, 1'b0, 1'b0, done_cyc);
        check("tie_max",   64'(new_max_result), 64'h0000_0000_FFFF_FFFD);
        check("tie_class", 64'(new_max_class), 64'd5);
        tick();

        // Positive saturation on class 9.
        fill_const(32'd0);
        mem[9] = '{32'h7000_0000, 32'h7000_0000, 32'h7000_0000, 32'h7000_0000};
        run_sweep(32'hFFFF_FFFF, 1'b0, 1'b0, done_cyc);
        check("sat_max",   64'(new_max_result), 64'h0000_0000_7FFF_FFFF);
        check("sat_class", 64'(new_max_class), 64'd9);
        tick();

        // No classes enabled.
        fill_basic();
        run_sweep(32'h0000_0000, 1'b0, 1'b0, done_cyc);
        check("none_max",   64'(new_max_result), 64'h0000_0000_8000_0000);
        check("none_class", 64'(new_max_class), 64'd0);
        tick();

        // Start re-pulse and load_mode while busy are ignored.
        load_mode = 1'b1;
        run_sweep(32'hFFFF_FFFF, 1'b0, 1'b1, done_cyc);
        check("ctl_max", 64'(new_max_result), 64'd124);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ctl_no_second_done", 64'({busy, done}), 64'd0);
        end
        check("ctl_we_idle", 64'(we), 64'd1);
        check("ctl_hold_class", 64'(new_max_class), 64'd31);
        load_mode = 1'b0;
        tick();

        // Reset mid-sweep at cycle 20, then a clean sweep.
        used_classes = 32'hFFFF_FFFF;
        gbdt_start   = 1'b1;
        tick();
        gbdt_start   = 1'b0;
        for (int i = 1; i < 20; i++) tick();
        gbdt_rst_n = 1'b0;
        #1;
        check("mid_rst_ctl",   64'({cs, oe, busy, done, round}), 64'd0);
        check("mid_rst_addr",  64'(ram_address), 64'd0);
        check("mid_rst_max",   64'(new_max_result), 64'd0);
        check("mid_rst_class", 64'(new_max_class), 64'd0);
        tick();
        gbdt_rst_n = 1'b1;
        tick();
        run_sweep(32'h0000_FF00, 1'b0, 1'b0, done_cyc);
        check("post_rst_max",   64'(new_max_result), 64'd60);
        check("post_rst_class", 64'(new_max_class), 64'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
